// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage with ALU-control decode, ALU and branch-target adder, one-cycle registered outputs
module alu_exec_unit #(
  parameter int WIDTH    = 64,
  parameter int BR_SHIFT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic [WIDTH-1:0] add_alu_out
);
  localparam int SW = $clog2(WIDTH);
  logic [3:0]       ctl;
  logic [3:0]       rctl;
  logic [WIDTH-1:0] res;
  logic [SW-1:0]    sh;
  assign sh = b[SW-1:0];
  // I-type never subtracts: funct7b5 only selects SUB for R-type funct3=000
  always_comb begin
    rctl = 4'b0010;
    case (funct3)
      3'b000: rctl = (!alu_op[0] && funct7b5) ? 4'b0110 : 4'b0010;
      3'b001: rctl = 4'b0100;
      3'b010: rctl = 4'b0111;
      3'b011: rctl = 4'b1000;
      3'b100: rctl = 4'b0011;
      3'b101: rctl = funct7b5 ? 4'b1001 : 4'b0101;
      3'b110: rctl = 4'b0001;
      default: rctl = 4'b0000;
    endcase
    ctl = alu_op[1] ? rctl : (alu_op[0] ? 4'b0110 : 4'b0010);
  end
  always_comb begin
    res = '0;
    case (ctl)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0010: res = a + b;
      4'b0011: res = a ^ b;
      4'b0100: res = a << sh;
      4'b0101: res = a >> sh;
      4'b0110: res = a - b;
      4'b0111: res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1000: res = {{(WIDTH-1){1'b0}}, a < b};
      4'b1001: res = $signed(a) >>> sh;
      default: res = '0;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      alu_ctl     <= '0;
      alu_out     <= '0;
      zero        <= 1'b0;
      add_alu_out <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_ctl     <= ctl;
        alu_out     <= res;
        zero        <= (res == '0);
        add_alu_out <= pc + (imm << BR_SHIFT);
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit (WIDTH=64, BR_SHIFT=1)
module tb_alu_exec_unit;
  logic        clock, reset, in_valid, funct7b5;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [63:0] a, b, pc, imm;
  logic        out_valid, zero;
  logic [3:0]  alu_ctl;
  logic [63:0] alu_out, add_alu_out;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [3:0]  ctl;
    logic [63:0] res;
    logic        z;
    logic [63:0] br;
  } exp_t;
  exp_t sb[$];
  alu_exec_unit dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .alu_op(alu_op),
    .funct3(funct3), .funct7b5(funct7b5), .a(a), .b(b), .pc(pc), .imm(imm),
    .out_valid(out_valid), .alu_ctl(alu_ctl), .alu_out(alu_out), .zero(zero),
    .add_alu_out(add_alu_out)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] m_ctl(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    case (f3)
      3'd0: return (op == 2'b10 && f7) ? 4'b0110 : 4'b0010;
      3'd1: return 4'b0100;
      3'd2: return 4'b0111;
      3'd3: return 4'b1000;
      3'd4: return 4'b0011;
      3'd5: return f7 ? 4'b1001 : 4'b0101;
      3'd6: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction
  function automatic logic [63:0] m_res(input logic [3:0] c, input logic [63:0] x, input logic [63:0] y);
    int s;
    s = int'(y[5:0]);
    case (c)
      4'd0: return x & y;
      4'd1: return x | y;
      4'd2: return x + y;
      4'd3: return x ^ y;
      4'd4: return x << s;
      4'd5: return x >> s;
      4'd6: return x - y;
      4'd7: return (x[63] != y[63]) ? {63'd0, x[63]} : {63'd0, x < y};
      4'd8: return {63'd0, x < y};
      4'd9: return (x >> s) | (x[63] ? ~(~64'd0 >> s) : 64'd0);
      default: return 64'd0;
    endcase
  endfunction
  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic [63:0] x, input logic [63:0] y, input logic [63:0] p, input logic [63:0] i);
    in_valid = 1'b1; alu_op = op; funct3 = f3; funct7b5 = f7;
    a = x; b = y; pc = p; imm = i;
  endtask
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                      input logic [63:0] x, input logic [63:0] y, input logic [63:0] p, input logic [63:0] i);
    exp_t e;
    e.ctl = m_ctl(op, f3, f7);
    e.res = m_res(e.ctl, x, y);
    e.z   = (e.res == 64'd0);
    e.br  = p + (i << 1);
    drive(op, f3, f7, x, y, p, i);
    sb.push_back(e);
    @(negedge clock);
  endtask
  task automatic send_e(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic [63:0] x, input logic [63:0] y, input logic [63:0] p, input logic [63:0] i,
                        input logic [3:0] ec, input logic [63:0] er, input logic [63:0] eb);
    exp_t e;
    e.ctl = ec; e.res = er; e.z = (er == 64'd0); e.br = eb;
    drive(op, f3, f7, x, y, p, i);
    sb.push_back(e);
    @(negedge clock);
  endtask
  task automatic check_zeroed(input string tag);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_ctl"}, {60'd0, alu_ctl}, 64'd0);
    check({tag, "_out"}, alu_out, 64'd0);
    check({tag, "_zero"}, {63'd0, zero}, 64'd0);
    check({tag, "_br"}, add_alu_out, 64'd0);
  endtask
  // Outputs are stable at the falling edge; every valid output retires the oldest expectation
  always @(negedge clock) begin
    if (out_valid) begin
      if (sb.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("alu_ctl", {60'd0, alu_ctl}, {60'd0, e.ctl});
        check("alu_out", alu_out, e.res);
        check("zero", {63'd0, zero}, {63'd0, e.z});
        check("add_alu_out", add_alu_out, e.br);
      end
    end
  end
  initial begin
    reset = 1'b1; drive(2'b00, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0); in_valid = 1'b0;
    @(negedge clock);
    check_zeroed("reset_state");
    reset = 1'b0;
    // Reset right behind a valid ADD, held with in_valid=1
    send_e(2'b00, 3'd0, 1'b0, 64'd1, 64'd2, 64'h10, 64'h1, 4'b0010, 64'd3, 64'h12);
    reset = 1'b1;
    @(negedge clock);
    check_zeroed("reset_mid");
    @(negedge clock);
    check_zeroed("reset_held");
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    for (int op = 0; op < 4; op++)
      for (int f = 0; f < 16; f++)
        send(op[1:0], f[2:0], f[3], {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    send_e(2'b11, 3'd0, 1'b1, 64'd7, 64'd3, 64'd0, 64'd0, 4'b0010, 64'd10, 64'd0);
    send_e(2'b10, 3'd5, 1'b1, 64'h8000_0000_0000_0000, 64'h43, 64'd0, 64'd0, 4'b1001, 64'hF000_0000_0000_0000, 64'd0);
    send_e(2'b10, 3'd5, 1'b0, 64'h8000_0000_0000_0000, 64'h43, 64'd0, 64'd0, 4'b0101, 64'h1000_0000_0000_0000, 64'd0);
    send_e(2'b00, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h100, 64'h10, 4'b0010, 64'd0, 64'h120);
    send_e(2'b01, 3'd0, 1'b0, 64'd5, 64'd5, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 4'b0110, 64'd0, 64'hF0);
    send_e(2'b01, 3'd0, 1'b0, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'd4, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 64'd4);
    send_e(2'b10, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 4'b0111, 64'd1, 64'd0);
    send_e(2'b10, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 4'b1000, 64'd0, 64'd0);
    send_e(2'b10, 3'd6, 1'b0, 64'hF0, 64'h0F, 64'h200, 64'h2, 4'b0001, 64'hFF, 64'h204);
    drive(2'b10, 3'd0, 1'b1, 64'h1234, 64'h1234, 64'h0, 64'h0);
    in_valid = 1'b0;
    @(negedge clock);
    check("hold_valid", {63'd0, out_valid}, 64'd0);
    check("hold_out", alu_out, 64'hFF);
    check("hold_ctl", {60'd0, alu_ctl}, 64'd1);
    check("hold_br", add_alu_out, 64'h204);
    repeat (3) @(negedge clock);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
